seq_divider_16: RTL and testbench

Sequential restoring integer divider, the inverse datapath to the Booth multiplier. It takes one operand pair over a valid/ready handshake and produces quotient and remainder one bit per cycle. Each trial subtraction goes through one cla_16 instance, driven with A = partial remainder, B = ~divisor, Cin = 1. It supports unsigned and two's-complement signed modes.

---
 rtl/seq_divider_16.sv | 175 +++++++++++++++++
 tb/tb_seq_divider_16.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_16.sv
// Sequential restoring divider: one quotient bit per cycle, trial subtraction through cla_16.
// Unsigned or two's-complement operands; results are held until the consumer handshakes.

module cla_16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   logic [15:0] g;
   logic [15:0] p;
   logic [16:0] c;
   logic [3:0]  gg;
   logic [3:0]  gp;

   // Four 4-bit lookahead groups; group carries first, then carries inside each group.
   always_comb begin
      g  = a & b;
      p  = a ^ b;
      gg = '0;
      gp = '0;
      c  = '0;
      c[0] = cin;
      for (int unsigned k = 0; k < 4; k++) begin
         gg[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         gp[k] = &p[4*k +: 4];
      end
      for (int unsigned k = 0; k < 4; k++) begin
         c[4*(k+1)] = gg[k] | (gp[k] & c[4*k]);
      end
      for (int unsigned i = 0; i < 16; i++) begin
         if ((i % 4) != 3) begin
            c[i+1] = g[i] | (p[i] & c[i]);
         end
      end
      sum  = p ^ c[15:0];
      cout = c[16];
   end

endmodule

module seq_divider_16 #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] SIGN = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dsr;
   logic             neg_q;
   logic             neg_r;

   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] dsr_n;
   logic [WIDTH-1:0] diff;
   logic             cout;
   logic             ge;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   // Shifted remainder needs one extra bit; a set top bit always means it exceeds the divisor.
   assign rem_sh = {rem, dvd[WIDTH-1]};
   assign dsr_n  = ~dsr;
   assign ge     = rem_sh[WIDTH] | cout;

   cla_16 u_cla (
      .a    (rem_sh[WIDTH-1:0]),
      .b    (dsr_n),
      .cin  (1'b1),
      .sum  (diff),
      .cout (cout)
   );

   always_comb begin
      a_mag = (signed_mode && dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
      b_mag = (signed_mode && divisor[WIDTH-1])  ? (~divisor + WIDTH'(1))  : divisor;
      q_fix = neg_q ? (~dvd + WIDTH'(1)) : dvd;
      r_fix = neg_r ? (~rem + WIDTH'(1)) : rem;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         rem         <= '0;
         dvd         <= '0;
         dsr         <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         out_valid   <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (divisor == '0) begin
                     // Raw dividend is kept so it can be returned unmodified as the remainder.
                     dvd   <= dividend;
                     state <= DONE;
                  end else begin
                     dvd   <= a_mag;
                     dsr   <= b_mag;
                     neg_q <= signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                     neg_r <= signed_mode & dividend[WIDTH-1];
                     rem   <= '0;
                     cnt   <= CNT_W'(WIDTH - 1);
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               rem <= ge ? diff : rem_sh[WIDTH-1:0];
               dvd <= {dvd[WIDTH-2:0], ge};
               cnt <= cnt - CNT_W'(1);
               if (cnt == '0) begin
                  state <= SIGN;
               end
            end
            SIGN: begin
               quotient    <= q_fix;
               remainder   <= r_fix;
               div_by_zero <= 1'b0;
               out_valid   <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               if (!out_valid) begin
                  quotient    <= '1;
                  remainder   <= dvd;
                  div_by_zero <= 1'b1;
                  out_valid   <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider_16.sv
// Directed-vector bench for seq_divider_16: latency, signed/unsigned results, corners,
// divide-by-zero, backpressure and mid-operation reset.

module tb_seq_divider_16;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        signed_mode;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;
   logic        busy;

   int n_cmp;
   int n_bad;

   seq_divider_16 #(.WIDTH(16), .CNT_W(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .signed_mode (signed_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one operand pair and count cycles from the accept edge to out_valid (-1 on timeout).
   task automatic start_div(input logic [15:0] a, input logic [15:0] b, input logic sm,
                            output int lat);
      int w;
      w = 0;
      while (!in_ready && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      dividend    = a;
      divisor     = b;
      signed_mode = sm;
      in_valid    = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_cmp++;
      if ({in_ready, busy, out_valid} !== 3'b100) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b want 100", {in_ready, busy, out_valid});
      end
      n_cmp++;
      if ({quotient, remainder, div_by_zero} !== 33'h0) begin
         n_bad++;
         $display("FAIL reset_data: got %h want 0", {quotient, remainder, div_by_zero});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int lat;
      logic [15:0] a [3] = '{16'd100, 16'hFF9C, 16'd100};
      logic [15:0] b [3] = '{16'd7,   16'd7,    16'hFFF9};
      logic        s [3] = '{1'b0,    1'b1,     1'b1};
      logic [32:0] e [3] = '{{16'h000E, 16'h0002, 1'b0},
                             {16'hFFF2, 16'hFFFE, 1'b0},
                             {16'hFFF2, 16'h0002, 1'b0}};
      for (int i = 0; i < 3; i++) begin
         start_div(a[i], b[i], s[i], lat);
         n_cmp++;
         if (lat !== 17) begin
            n_bad++;
            $display("FAIL basic_latency[%0d]: got %0d want 17", i, lat);
         end
         n_cmp++;
         if ({quotient, remainder, div_by_zero} !== e[i]) begin
            n_bad++;
            $display("FAIL basic_result[%0d]: got %h want %h", i,
                     {quotient, remainder, div_by_zero}, e[i]);
         end
         release_result();
      end
   endtask

   task automatic test_corners();
      int lat;
      logic [15:0] a [4] = '{16'hFFFF, 16'h8000, 16'd5, 16'hFFF9};
      logic [15:0] b [4] = '{16'h0001, 16'hFFFF, 16'd9, 16'hFFFE};
      logic        s [4] = '{1'b0,     1'b1,     1'b0,  1'b1};
      logic [32:0] e [4] = '{{16'hFFFF, 16'h0000, 1'b0},
                             {16'h8000, 16'h0000, 1'b0},
                             {16'h0000, 16'h0005, 1'b0},
                             {16'h0003, 16'hFFFF, 1'b0}};
      for (int i = 0; i < 4; i++) begin
         start_div(a[i], b[i], s[i], lat);
         n_cmp++;
         if (lat !== 17 || {quotient, remainder, div_by_zero} !== e[i]) begin
            n_bad++;
            $display("FAIL corner[%0d]: got lat %0d res %h want lat 17 res %h", i, lat,
                     {quotient, remainder, div_by_zero}, e[i]);
         end
         release_result();
      end
   endtask

   task automatic test_div_by_zero();
      int lat;
      start_div(16'h04D2, 16'h0000, 1'b0, lat);
      n_cmp++;
      if (lat !== 1) begin
         n_bad++;
         $display("FAIL dbz_latency: got %0d want 1", lat);
      end
      n_cmp++;
      if ({quotient, remainder, div_by_zero} !== {16'hFFFF, 16'h04D2, 1'b1}) begin
         n_bad++;
         $display("FAIL dbz_result: got %h want %h", {quotient, remainder, div_by_zero},
                  {16'hFFFF, 16'h04D2, 1'b1});
      end
      release_result();
      start_div(16'h8000, 16'h0000, 1'b1, lat);
      n_cmp++;
      if (lat !== 1 || {quotient, remainder, div_by_zero} !== {16'hFFFF, 16'h8000, 1'b1}) begin
         n_bad++;
         $display("FAIL dbz_signed: got lat %0d res %h want lat 1 res %h", lat,
                  {quotient, remainder, div_by_zero}, {16'hFFFF, 16'h8000, 1'b1});
      end
      release_result();
   endtask

   task automatic test_backpressure();
      int lat;
      // 200 / 3 with junk operands toggled on in_valid while the divider is busy.
      dividend    = 16'd200;
      divisor     = 16'd3;
      signed_mode = 1'b0;
      in_valid    = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         in_valid    = ~in_valid;
         dividend    = 16'h1234 + 16'(lat);
         divisor     = 16'h0000;
         signed_mode = lat[0];
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      n_cmp++;
      if (lat !== 17 || {quotient, remainder, div_by_zero} !== {16'd66, 16'd2, 1'b0}) begin
         n_bad++;
         $display("FAIL bp_result: got lat %0d res %h want lat 17 res %h", lat,
                  {quotient, remainder, div_by_zero}, {16'd66, 16'd2, 1'b0});
      end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         n_cmp++;
         if ({out_valid, in_ready, quotient, remainder, div_by_zero} !==
             {1'b1, 1'b0, 16'd66, 16'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL bp_hold[%0d]: got %h want %h", c,
                     {out_valid, in_ready, quotient, remainder, div_by_zero},
                     {1'b1, 1'b0, 16'd66, 16'd2, 1'b0});
         end
      end
      release_result();
      n_cmp++;
      if ({out_valid, in_ready, busy, quotient, remainder} !== {3'b010, 16'd66, 16'd2}) begin
         n_bad++;
         $display("FAIL bp_after: got %h want %h", {out_valid, in_ready, busy, quotient, remainder},
                  {3'b010, 16'd66, 16'd2});
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      dividend    = 16'hFFFF;
      divisor     = 16'h0001;
      signed_mode = 1'b0;
      in_valid    = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({out_valid, in_ready, busy, quotient, remainder, div_by_zero} !== {3'b010, 33'h0}) begin
         n_bad++;
         $display("FAIL mid_reset: got %h want %h",
                  {out_valid, in_ready, busy, quotient, remainder, div_by_zero}, {3'b010, 33'h0});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      start_div(16'd1000, 16'd10, 1'b0, lat);
      n_cmp++;
      if (lat !== 17 || {quotient, remainder, div_by_zero} !== {16'd100, 16'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL post_reset_div: got lat %0d res %h want lat 17 res %h", lat,
                  {quotient, remainder, div_by_zero}, {16'd100, 16'd0, 1'b0});
      end
      release_result();
   endtask

   initial begin
      n_cmp       = 0;
      n_bad       = 0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      dividend    = '0;
      divisor     = '0;
      signed_mode = 1'b0;
      rst_n       = 1'b1;
      test_reset();
      test_basic();
      test_corners();
      test_div_by_zero();
      test_backpressure();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
